// File: rtl/legv8_seq_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: states, opcodes, ALU/PC codes,
// condition codes and control-word bit offsets, plus the opcode classifier.
package legv8_seq_pkg;

  localparam int CW_WIDTH = 93;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_MEM   = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_REG  = 2'b11;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01011;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // Bit offsets from the LSB; PCsel is never asserted, so the word carries no bit for it.
  localparam int CW_DA     = 0;
  localparam int CW_SA     = 5;
  localparam int CW_SB     = 10;
  localparam int CW_FS     = 15;
  localparam int CW_PS     = 20;
  localparam int CW_WR     = 22;
  localparam int CW_WM     = 23;
  localparam int CW_SL     = 24;
  localparam int CW_BSEL   = 25;
  localparam int CW_EN_ALU = 26;
  localparam int CW_EN_MEM = 27;
  localparam int CW_EN_PC  = 28;
  localparam int CW_CONST  = 29;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_BR   = 11'b11010110000;

  localparam logic [9:0] OPC_ADDI  = 10'b1001000100;
  localparam logic [9:0] OPC_ADDIS = 10'b1011000100;
  localparam logic [9:0] OPC_SUBI  = 10'b1101000100;
  localparam logic [9:0] OPC_SUBIS = 10'b1111000100;
  localparam logic [9:0] OPC_ANDI  = 10'b1001001000;
  localparam logic [9:0] OPC_ORRI  = 10'b1011001000;
  localparam logic [9:0] OPC_EORI  = 10'b1101001000;

  localparam logic [7:0] OPC_CBZ   = 8'b10110100;
  localparam logic [7:0] OPC_CBNZ  = 8'b10110101;
  localparam logic [7:0] OPC_BCOND = 8'b01010100;

  localparam logic [5:0] OPC_B  = 6'b000101;
  localparam logic [5:0] OPC_BL = 6'b100101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;

  typedef enum logic [4:0] {
    OP_ILLEGAL, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR,
    OP_LSL, OP_LSR, OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS, OP_ANDI, OP_ORRI,
    OP_EORI, OP_LDUR, OP_STUR, OP_BR, OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND
  } op_t;

  // Shortest opcodes are matched first so that longer matches overwrite them.
  function automatic op_t classify(input logic [31:0] ir);
    op_t op;
    op = OP_ILLEGAL;
    case (ir[31:26])
      OPC_B:   op = OP_B;
      OPC_BL:  op = OP_BL;
      default: ;
    endcase
    case (ir[31:24])
      OPC_CBZ:   op = OP_CBZ;
      OPC_CBNZ:  op = OP_CBNZ;
      OPC_BCOND: op = OP_BCOND;
      default:   ;
    endcase
    case (ir[31:22])
      OPC_ADDI:  op = OP_ADDI;
      OPC_ADDIS: op = OP_ADDIS;
      OPC_SUBI:  op = OP_SUBI;
      OPC_SUBIS: op = OP_SUBIS;
      OPC_ANDI:  op = OP_ANDI;
      OPC_ORRI:  op = OP_ORRI;
      OPC_EORI:  op = OP_EORI;
      default:   ;
    endcase
    case (ir[31:21])
      OPC_ADD:  op = OP_ADD;
      OPC_ADDS: op = OP_ADDS;
      OPC_SUB:  op = OP_SUB;
      OPC_SUBS: op = OP_SUBS;
      OPC_AND:  op = OP_AND;
      OPC_ORR:  op = OP_ORR;
      OPC_EOR:  op = OP_EOR;
      OPC_LSL:  op = OP_LSL;
      OPC_LSR:  op = OP_LSR;
      OPC_LDUR: op = OP_LDUR;
      OPC_STUR: op = OP_STUR;
      OPC_BR:   op = OP_BR;
      default:  ;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] alu_fs(input op_t op);
    logic [4:0] fs;
    case (op)
      OP_SUB, OP_SUBS, OP_SUBI, OP_SUBIS: fs = FS_SUB;
      OP_AND, OP_ANDI:                    fs = FS_AND;
      OP_ORR, OP_ORRI:                    fs = FS_ORR;
      OP_EOR, OP_EORI:                    fs = FS_EOR;
      OP_LSL:                             fs = FS_LSL;
      OP_LSR:                             fs = FS_LSR;
      default:                            fs = FS_ADD;
    endcase
    return fs;
  endfunction

  function automatic logic sets_flags(input op_t op);
    return (op == OP_ADDS) || (op == OP_SUBS) || (op == OP_ADDIS) || (op == OP_SUBIS);
  endfunction

endpackage

// File: rtl/legv8_seq_decode.sv
// Purely combinational decode of (IR, state, status) into the datapath control word.
// LEGV8_SEQ_ILLEGAL_TRAP_EN selects whether an unmatched opcode is a NOP or emits zero.
module legv8_seq_decode
  import legv8_seq_pkg::*;
(
  input  logic [31:0]         ir,
  input  seq_state_t          state,
  input  logic [4:0]          status,
  output logic [CW_WIDTH-1:0] control_word
);

  op_t         op;
  logic [4:0]  rd, rn, rm;
  logic [63:0] k_shamt, k_imm12, k_dt, k_b, k_cb;
  logic        flag_v, flag_c, flag_n, flag_z, cond_gt, cond_taken;

  logic [4:0]  da, sa, sb, fs;
  logic [1:0]  ps;
  logic        wr, wm, sl, bsel, en_alu, en_mem, en_pc;
  logic [63:0] konst;

  assign op      = classify(ir);
  assign rd      = ir[4:0];
  assign rn      = ir[9:5];
  assign rm      = ir[20:16];
  assign k_shamt = {58'd0, ir[15:10]};
  assign k_imm12 = {52'd0, ir[21:10]};
  assign k_dt    = {{55{ir[20]}}, ir[20:12]};
  assign k_b     = {{36{ir[25]}}, ir[25:0], 2'b00};
  assign k_cb    = {{43{ir[23]}}, ir[23:5], 2'b00};

  assign flag_v  = status[4];
  assign flag_c  = status[3];
  assign flag_n  = status[2];
  assign flag_z  = status[1];
  assign cond_gt = !flag_z && (flag_n == flag_v);

  always_comb begin
    cond_taken = 1'b0;
    case (ir[3:0])
      COND_EQ: cond_taken = flag_z;
      COND_NE: cond_taken = !flag_z;
      COND_HS: cond_taken = flag_c;
      COND_LO: cond_taken = !flag_c;
      COND_MI: cond_taken = flag_n;
      COND_PL: cond_taken = !flag_n;
      COND_VS: cond_taken = flag_v;
      COND_VC: cond_taken = !flag_v;
      COND_GE: cond_taken = (flag_n == flag_v);
      COND_LT: cond_taken = (flag_n != flag_v);
      COND_GT: cond_taken = cond_gt;
      COND_LE: cond_taken = !cond_gt;
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    da = '0; sa = '0; sb = '0; fs = '0; ps = PS_HOLD;
    wr = 1'b0; wm = 1'b0; sl = 1'b0; bsel = 1'b0;
    en_alu = 1'b0; en_mem = 1'b0; en_pc = 1'b0; konst = '0;
    case (state)
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR: begin
            sa = rn; sb = rm; da = rd; fs = alu_fs(op); sl = sets_flags(op);
            en_alu = 1'b1; wr = 1'b1; ps = PS_INC;
            if (op == OP_LSL || op == OP_LSR) begin
              bsel  = 1'b1;
              konst = k_shamt;
            end
          end
          OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS, OP_ANDI, OP_ORRI, OP_EORI: begin
            sa = rn; da = rd; fs = alu_fs(op); sl = sets_flags(op);
            bsel = 1'b1; konst = k_imm12; en_alu = 1'b1; wr = 1'b1; ps = PS_INC;
          end
          OP_STUR: begin
            sa = rn; sb = rd; bsel = 1'b1; konst = k_dt; fs = FS_ADD;
            wm = 1'b1; ps = PS_INC;
          end
          // The load only presents its address here; the write-back happens in MEM.
          OP_LDUR: begin
            sa = rn; bsel = 1'b1; konst = k_dt; fs = FS_ADD; ps = PS_HOLD;
          end
          OP_B: begin
            ps = PS_REL; konst = k_b;
          end
          OP_BL: begin
            ps = PS_REL; konst = k_b; en_pc = 1'b1; wr = 1'b1; da = 5'd30;
          end
          OP_BR: begin
            sa = rn; ps = PS_REG;
          end
          OP_CBZ, OP_CBNZ: begin
            sa = rd; bsel = 1'b1; fs = FS_ADD; konst = k_cb;
            ps = (status[0] == (op == OP_CBZ)) ? PS_REL : PS_INC;
          end
          OP_BCOND: begin
            konst = k_cb;
            ps = cond_taken ? PS_REL : PS_INC;
          end
`ifdef LEGV8_SEQ_ILLEGAL_TRAP_EN
          default: ;
`else
          default: ps = PS_INC;
`endif
        endcase
      end
      ST_MEM: begin
        sa = rn; bsel = 1'b1; konst = k_dt; fs = FS_ADD;
        en_mem = 1'b1; wr = 1'b1; da = rd; ps = PS_INC;
      end
      default: ;
    endcase
  end

  always_comb begin
    control_word                        = '0;
    control_word[CW_DA +: 5]            = da;
    control_word[CW_SA +: 5]            = sa;
    control_word[CW_SB +: 5]            = sb;
    control_word[CW_FS +: 5]            = fs;
    control_word[CW_PS +: 2]            = ps;
    control_word[CW_WR]                 = wr;
    control_word[CW_WM]                 = wm;
    control_word[CW_SL]                 = sl;
    control_word[CW_BSEL]               = bsel;
    control_word[CW_EN_ALU]             = en_alu;
    control_word[CW_EN_MEM]             = en_mem;
    control_word[CW_EN_PC]              = en_pc;
    control_word[CW_CONST +: 64]        = konst;
  end

endmodule

// File: rtl/legv8_seq_control.sv
// LEGv8 multi-cycle sequencer top: owns the instruction register and the FSM.
// Define LEGV8_SEQ_ILLEGAL_TRAP_EN to halt on unmatched opcodes instead of skipping them.
module legv8_seq_control
  import legv8_seq_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [4:0]          status,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [1:0]          state,
  output logic                halted
);

  seq_state_t  curr_state, next_state;
  logic [31:0] ir;
  op_t         op;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) curr_state <= ST_FETCH;
    else       curr_state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       ir <= '0;
    else if (curr_state == ST_FETCH) ir <= instruction;
  end

  assign op = classify(ir);

  always_comb begin
    next_state = curr_state;
    case (curr_state)
      ST_FETCH: next_state = ST_EXEC;
      ST_EXEC: begin
        next_state = ST_FETCH;
        if (op == OP_LDUR) next_state = ST_MEM;
`ifdef LEGV8_SEQ_ILLEGAL_TRAP_EN
        else if (op == OP_ILLEGAL) next_state = ST_HALT;
`endif
      end
      ST_MEM:  next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    state = curr_state;
`ifdef LEGV8_SEQ_ILLEGAL_TRAP_EN
    halted = (curr_state == ST_HALT);
`else
    halted = 1'b0;
`endif
  end

  legv8_seq_decode u_decode (
    .ir           (ir),
    .state        (curr_state),
    .status       (status),
    .control_word (control_word)
  );

endmodule
